// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register family: mode encoding
// and the counter-width helper used to size frame counters.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    // Width needed to count 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        if (w <= 2) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Modulo-MOD counter with a registered one-cycle wrap pulse; reusable by
// serialisers that need frame boundaries.
module frame_counter #(
    parameter int MOD   = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (!en) begin
            r_wrap <= 1'b0;
        end else begin
            // clr has priority: a load never reports a wrap
            r_wrap <= inc && !clr && w_at_last;
            if (clr) begin
                r_cnt <= '0;
            end else if (inc) begin
                r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;

endmodule

// File: rtl/univ_shift_reg.sv
// Edge-triggered universal register: hold, load, shift/rotate both ways,
// complementary and serial outputs, plus a shift-frame counter.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    mode_t            w_mode;
    logic [WIDTH-1:0] r_q;
    logic             w_in_r;
    logic             w_in_l;
    logic             w_shift;
    logic             w_load;

    assign w_mode  = mode_t'(mode);
    assign w_in_r  = rotate ? r_q[0]       : sin_r;
    assign w_in_l  = rotate ? r_q[WIDTH-1] : sin_l;
    assign w_shift = (w_mode == MODE_SHR) || (w_mode == MODE_SHL);
    assign w_load  = (w_mode == MODE_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            case (w_mode)
                MODE_SHR:  r_q <= {w_in_r, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], w_in_l};
                MODE_LOAD: r_q <= d;
                default:   r_q <= r_q;
            endcase
        end
    end

    frame_counter #(
        .MOD   (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inc   (w_shift),
        .clr   (w_load),
        .cnt   (shift_cnt),
        .wrap  (frame_done)
    );

    assign q      = r_q;
    assign q_not  = ~r_q;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): directed scenarios then
// randomized traffic against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       rotate = 1'b0;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q;
    logic [7:0] q_not;
    logic       sout_r;
    logic       sout_l;
    logic [2:0] shift_cnt;
    logic       frame_done;

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .rotate     (rotate),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .d          (d),
        .q          (q),
        .q_not      (q_not),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic [2:0] cnt;
        logic       fd;
    } exp_t;

    exp_t sync_q[$];
    exp_t async_q[$];
    int   total = 0;
    int   bad = 0;
    event async_ev;

    // Reference model state
    int m_q   = 0;
    int m_cnt = 0;
    bit m_fd  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        logic [7:0] nq;
        nq = ~e.q;
        chk({tag, ".q"},          32'(q),          32'(e.q));
        chk({tag, ".q_not"},      32'(q_not),      32'(nq));
        chk({tag, ".sout_r"},     32'(sout_r),     32'(e.q[0]));
        chk({tag, ".sout_l"},     32'(sout_l),     32'(e.q[7]));
        chk({tag, ".shift_cnt"},  32'(shift_cnt),  32'(e.cnt));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(e.fd));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sync_q.size() > 0) compare("edge", sync_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(async_ev);
            #1;
            if (async_q.size() > 0) compare("reset", async_q.pop_front());
        end
    end

    task automatic model_edge(input bit e, input bit [1:0] md, input bit rot,
                              input bit sr, input bit sl, input bit [7:0] dd);
        bit shifted;
        int inb;
        shifted = 1'b0;
        if (!e) begin
            m_fd = 1'b0;
            return;
        end
        case (md)
            2'd1: begin
                inb = rot ? (m_q % 2) : int'(sr);
                m_q = (m_q / 2) + inb * 128;
                shifted = 1'b1;
            end
            2'd2: begin
                inb = rot ? (m_q / 128) : int'(sl);
                m_q = ((m_q * 2) % 256) + inb;
                shifted = 1'b1;
            end
            2'd3: begin
                m_q = int'(dd);
                m_cnt = 0;
            end
            default: ;
        endcase
        m_fd = shifted && (m_cnt == W - 1);
        if (shifted) m_cnt = (m_cnt + 1) % W;
    endtask

    task automatic push_model(input bit is_async);
        exp_t e;
        e.q   = 8'(m_q);
        e.cnt = 3'(m_cnt);
        e.fd  = m_fd;
        if (is_async) async_q.push_back(e);
        else          sync_q.push_back(e);
    endtask

    // Drives one cycle of stimulus; d glitches between edges must be ignored.
    task automatic step(input bit e, input bit [1:0] md, input bit rot,
                        input bit sr, input bit sl, input bit [7:0] dd);
        @(negedge clk);
        en = e; mode = md; rotate = rot; sin_r = sr; sin_l = sl; d = dd;
        #1 d = ~dd;
        #1 d = dd;
        model_edge(e, md, rot, sr, sl, dd);
        push_model(1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        en = 1'b0;
        mode = 2'b00;
        #2 rst_n = 1'b0;
        m_q = 0; m_cnt = 0; m_fd = 1'b0;
        push_model(1'b1);
        -> async_ev;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_step();
        bit e;
        e = ($urandom_range(0, 9) != 0);
        step(e, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_pulse();

        step(1, 2'b11, 0, 0, 0, 8'hA5);
        repeat (8) step(1, 2'b01, 0, 1, 0, 8'h00);
        repeat (2) step(1, 2'b00, 0, 0, 0, 8'h00);

        step(1, 2'b11, 1, 0, 0, 8'h81);
        step(1, 2'b10, 1, 0, 0, 8'h00);
        step(1, 2'b01, 1, 0, 0, 8'h00);

        repeat (5) step(0, 2'b11, 0, 0, 0, 8'h3C);

        repeat (3) step(1, 2'b01, 0, 1'($urandom), 0, 8'h00);
        reset_pulse();
        repeat (8) step(1, 2'b10, 0, 0, 1'($urandom), 8'h00);
        repeat (2) step(1, 2'b00, 0, 0, 0, 8'h00);

        // wrap followed directly by a load
        step(1, 2'b11, 0, 0, 0, 8'h00);
        repeat (8) step(1, 2'b10, 0, 0, 1, 8'h00);
        step(1, 2'b11, 0, 0, 0, 8'h5A);
        step(1, 2'b00, 0, 0, 0, 8'h00);

        // back-to-back frames with mixed directions
        repeat (24) step(1, $urandom_range(0, 1) ? 2'b01 : 2'b10,
                         1'($urandom), 1'($urandom), 1'($urandom), 8'h00);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse();
            else                            rand_step();
        end

        for (int i = 0; i < 20 && (sync_q.size() > 0 || async_q.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (sync_q.size() != 0 || async_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sync_q.size() + async_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
